// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit logic unit between the
// execute stage (port 0) and the branch-compare path (port 1).
module logic_unit_arbiter #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [OUT_W-1:0]  rsp_data,
  output logic              rsp_eq,
  output logic              rsp_err,
  output logic [DATA_W-1:0] lu_a,
  output logic [DATA_W-1:0] lu_b,
  output logic [OP_W-1:0]   lu_opcode,
  input  logic [OUT_W-1:0]  lu_out,
  input  logic              lu_eq,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   owner;
  logic   gnt0, gnt1;
  logic   accept;
  logic   rsp_hs;

  // Only the four basic opcodes (MSB clear) are meaningful to the logic unit.
  function automatic logic op_invalid(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  always_comb begin
    // On contention, the port that was not served last wins.
    gnt0       = req0_valid & (~req1_valid | last_grant);
    gnt1       = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == IDLE) & gnt0 & ~rst;
    req1_ready = (state == IDLE) & gnt1 & ~rst;
    accept     = req0_ready | req1_ready;
    rsp0_valid = (state == RESP) & ~owner & ~rst;
    rsp1_valid = (state == RESP) &  owner & ~rst;
    rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
    busy       = (state != IDLE);

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lu_a       <= '0;
      lu_b       <= '0;
      lu_opcode  <= '0;
      rsp_data   <= '0;
      rsp_eq     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Accept: latch the winning request onto the logic unit inputs.
      if (accept) begin
        lu_a      <= gnt0 ? req0_a  : req1_a;
        lu_b      <= gnt0 ? req0_b  : req1_b;
        lu_opcode <= gnt0 ? req0_op : req1_op;
        owner     <= ~gnt0;
      end
      // Issue: logic unit has settled on stable inputs; capture its result.
      if (state == ISSUE) begin
        rsp_data <= lu_out;
        rsp_eq   <= lu_eq;
        rsp_err  <= op_invalid(lu_opcode);
      end
      // Response: result is held until the owner consumes it.
      if (rsp_hs) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a behavioural logic unit attached.
module tb_logic_unit_arbiter;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_eq, rsp_err;
  logic [15:0] lu_a, lu_b;
  logic [2:0]  lu_opcode;
  logic [31:0] lu_out;
  logic        lu_eq;
  logic        busy;

  logic        lu_force;
  logic [31:0] lu_junk;
  logic [15:0] lu_res;

  int n_vec = 0;
  int n_err = 0;

  logic_unit_arbiter #(.DATA_W(16), .OUT_W(32), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_eq(rsp_eq), .rsp_err(rsp_err),
    .lu_a(lu_a), .lu_b(lu_b), .lu_opcode(lu_opcode), .lu_out(lu_out), .lu_eq(lu_eq),
    .busy(busy)
  );

  // Behavioural logic unit
  always_comb begin
    case (lu_opcode)
      3'b000:  lu_res = lu_a & lu_b;
      3'b001:  lu_res = lu_a | lu_b;
      3'b010:  lu_res = lu_a ^ lu_b;
      3'b011:  lu_res = ~lu_a;
      default: lu_res = 16'h0000;
    endcase
  end
  assign lu_out = lu_force ? lu_junk : {16'h0000, lu_res};
  assign lu_eq  = (lu_a == lu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [31:0] exp_data;
    bit          exp_eq, exp_err;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspv(input bit p);
    return p ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic set_req(input bit p, input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    if (p) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ready on a port; result left for the caller to check.
  task automatic wait_ready(input bit p);
    for (int i = 0; i < 20 && !rdy(p); i++) tick();
  endtask

  // Drive a request up to the point where the response is presented.
  task automatic issue(input bit p, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input string nm);
    set_req(p, 1'b1, a, b, op);
    #1;
    wait_ready(p);
    check({nm, " ready"}, {31'd0, rdy(p)}, 32'd1);
    check({nm, " other ready"}, {31'd0, rdy(~p)}, 32'd0);
    tick();
    set_req(p, 1'b0, a, b, op);
    check({nm, " issue busy"}, {31'd0, busy}, 32'd1);
    check({nm, " no early rsp"}, {31'd0, rspv(p)}, 32'd0);
    tick();
    check({nm, " rsp valid"}, {31'd0, rspv(p)}, 32'd1);
    check({nm, " other rsp"}, {31'd0, rspv(~p)}, 32'd0);
  endtask

  task automatic finish_rsp(input bit p, input string nm);
    if (p) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check({nm, " rsp dropped"}, {31'd0, rspv(p)}, 32'd0);
    check({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] held;

  initial begin
    vecs[0] = '{1'b0, 16'hF0F0, 16'h0FF0, 3'b000, 32'h000000F0, 1'b0, 1'b0, "p0 and"};
    vecs[1] = '{1'b1, 16'hF0F0, 16'h0FF0, 3'b001, 32'h0000FFF0, 1'b0, 1'b0, "p1 or"};
    vecs[2] = '{1'b1, 16'hF0F0, 16'h0FF0, 3'b010, 32'h0000FF00, 1'b0, 1'b0, "p1 xor"};
    vecs[3] = '{1'b1, 16'hF0F0, 16'h0FF0, 3'b011, 32'h00000F0F, 1'b0, 1'b0, "p1 not"};
    vecs[4] = '{1'b1, 16'h1234, 16'h1234, 3'b000, 32'h00001234, 1'b1, 1'b0, "p1 eq"};
    vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 3'b101, 32'h00000000, 1'b1, 1'b1, "p0 badop"};

    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 16'h1111; req1_b = 16'h2222; req1_op = 3'b010;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    lu_force = 1'b0; lu_junk = 32'h0;

    // Reset state with requests pending
    #3;
    check("rst req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst lu_a", {16'd0, lu_a}, 32'd0);
    check("rst lu_opcode", {29'd0, lu_opcode}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].name);
      check({vecs[i].name, " data"}, rsp_data, vecs[i].exp_data);
      check({vecs[i].name, " eq"}, {31'd0, rsp_eq}, {31'd0, vecs[i].exp_eq});
      check({vecs[i].name, " err"}, {31'd0, rsp_err}, {31'd0, vecs[i].exp_err});
      finish_rsp(vecs[i].port, vecs[i].name);
    end

    // Contention: both continuously valid from reset, grants alternate 0,1,0,1
    do_reset();
    set_req(1'b0, 1'b1, 16'h00FF, 16'h0F0F, 3'b000);
    set_req(1'b1, 1'b1, 16'h00FF, 16'h0F0F, 3'b010);
    #1;
    for (int k = 0; k < 4; k++) begin
      bit p;
      p = bit'(k % 2);
      for (int w = 0; w < 20 && !(req0_ready | req1_ready); w++) tick();
      check("cont grant", {31'd0, rdy(p)}, 32'd1);
      check("cont single ready", {31'd0, rdy(~p)}, 32'd0);
      tick();
      check("cont issue busy", {31'd0, busy}, 32'd1);
      tick();
      check("cont owner rsp", {31'd0, rspv(p)}, 32'd1);
      check("cont other rsp", {31'd0, rspv(~p)}, 32'd0);
      check("cont data", rsp_data, p ? 32'h00000FF0 : 32'h0000000F);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      check("cont idle busy", {31'd0, busy}, 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Backpressure: response held while port 0 stalls
    issue(1'b0, 16'hF0F0, 16'h0FF0, 3'b001, "bp");
    held = rsp_data;
    check("bp data", held, 32'h0000FFF0);
    req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444; req1_op = 3'b000;
    lu_force = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req0_b = req0_b ^ 16'hFFFF;
      lu_junk = 32'hDEAD0000 + c;
      rsp1_ready = 1'b1;
      tick();
      check("bp held data", rsp_data, 32'h0000FFF0);
      check("bp held lu_b", {16'd0, lu_b}, 32'h00000FF0);
      check("bp req1_ready", {31'd0, req1_ready}, 32'd0);
      check("bp rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    end
    lu_force = 1'b0;
    rsp1_ready = 1'b0;
    finish_rsp(1'b0, "bp");
    req1_valid = 1'b0;
    tick();

    // Reset asserted mid-cycle while in RESP
    issue(1'b1, 16'h1234, 16'h00FF, 3'b001, "rr");
    check("rr data", rsp_data, 32'h000012FF);
    #2;
    rst = 1'b1;
    #1;
    check("rr rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rr busy", {31'd0, busy}, 32'd0);
    check("rr rsp_data", rsp_data, 32'd0);
    check("rr lu_a", {16'd0, lu_a}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rr ready in rst", {31'd0, req0_ready | req1_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rr p0 first", {31'd0, req0_ready}, 32'd1);
    check("rr p1 waits", {31'd0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    issue(1'b0, 16'h0F0F, 16'h0F0F, 3'b000, "post rst");
    check("post rst eq", {31'd0, rsp_eq}, 32'd1);
    finish_rsp(1'b0, "post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Two-requester controller that shares the single combinational 16-bit logic unit (AND/OR/XOR/NOT plus equality flag) between the execute stage (port 0) and the branch-compare path (port 1).
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Drives the shared unit's operand/opcode inputs from registers and captures its result and eq flag.
- Returns the result to the owning requester with a held valid/ready response.

Parameters:
- DATA_W, 16, operand width; matches the logic unit's a/b.
- OUT_W, 32, result width; matches the logic unit's output.
- OP_W, 3, opcode width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  port-0 request valid
- req0_ready  out  1  port-0 request accepted this cycle
- req0_a  in  DATA_W  port-0 operand a
- req0_b  in  DATA_W  port-0 operand b
- req0_op  in  OP_W  port-0 opcode
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same widths, port 1
- rsp0_valid  out  1  port-0 result valid
- rsp0_ready  in  1  port-0 result consumed
- rsp1_valid  out  1  port-1 result valid
- rsp1_ready  in  1  port-1 result consumed
- rsp_data  out  OUT_W  captured result, shared by both ports
- rsp_eq  out  1  captured equality flag
- rsp_err  out  1  captured opcode was outside 000-011
- lu_a  out  DATA_W  to logic unit a
- lu_b  out  DATA_W  to logic unit b
- lu_opcode  out  OP_W  to logic unit opcode
- lu_out  in  OUT_W  from logic unit result
- lu_eq  in  1  from logic unit eq
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, last_grant=1 (so port 0 wins the first contention).
  - lu_a, lu_b, lu_opcode, rsp_data, rsp_eq, rsp_err all 0.
  - owner=0; rspN_valid=0 and reqN_ready=0 while rst is high.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, grant that port. If both are high, grant the port != last_grant.
  - reqN_ready = (state==IDLE) & grant==N & !rst. At most one ready is high per cycle.
  - On the accept edge (valid&ready): register a/b/op into lu_a/lu_b/lu_opcode, set owner=N, go to ISSUE.
- ISSUE (1 cycle):
  - lu_* are stable; the logic unit settles combinationally.
  - At the end of the cycle capture rsp_data<=lu_out, rsp_eq<=lu_eq, rsp_err<=lu_opcode[2], then go to RESP.
- RESP:
  - rsp[owner]_valid=1; the other rsp valid is 0.
  - rsp_data, rsp_eq, rsp_err and lu_* are held stable until rsp[owner]_ready.
  - On the handshake edge: last_grant<=owner, go to IDLE.
- Latency and throughput:
  - Accept at edge T; ISSUE during cycle T..T+1; rspN_valid is high from edge T+1+1 (two cycles after accept).
  - Minimum 3 cycles per operation; no accept is possible in the same cycle as a response handshake.
- Requesters hold a/b/op stable while valid is high and ready is low. Valid may drop before ready with no side effect.
- Opcodes 100-111 are forwarded unchanged. The logic unit returns 0 for them; rsp_err=1 flags it, and the response still completes normally.
- rsp_eq reflects a==b of the captured operands regardless of opcode.
- Reset asserted in ISSUE or RESP: the transaction is discarded, no response is issued, and the FSM returns to IDLE asynchronously.
- The rsp_ready of the non-owning port is ignored.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1,...

Test Plan:
- Single op, port 0: a=F0F0, b=0FF0, op=000 -> req0_ready for 1 cycle; rsp0_valid 2 cycles later; rsp_data=000000F0, rsp_eq=0, rsp_err=0; rsp1_valid stays 0.
- All valid opcodes on port 1 with the same operands:
  - 001 -> 0000FFF0
  - 010 -> 0000FF00
  - 011 -> 00000F0F
  - a=b=1234, op=000 -> rsp_eq=1
- Contention: both ports valid from reset for 4 operations -> grants 0,1,0,1; each rsp goes only to the owner; busy is high except in the IDLE cycles.
- Backpressure: hold rsp0_ready=0 for 5 cycles in RESP, and toggle req0_b and lu_out meanwhile -> rsp_data unchanged, req1_ready=0 throughout; completes one cycle after rsp0_ready=1.
- Invalid opcode: op=101, a=FFFF, b=FFFF -> rsp_data=00000000, rsp_err=1, rsp_eq=1; the handshake completes.
- Reset in RESP: assert rst mid-cycle -> rspN_valid, busy and ready drop immediately, outputs go to 0; after release, a new port-0 request is granted first.
